// File: rtl/free_list_pkg.sv
// Free-list shared definitions.
// Holds the sizing constants for the physical-register free list, the
// permanent zero-register tags, and the packed bundles exchanged with the
// ROB and the map table.
package free_list_pkg;

  localparam int NUM_PR    = 64;
  localparam int PRW       = $clog2(NUM_PR);
  localparam int NUM_ARCH  = 32;
  localparam int NUM_FL    = NUM_PR - NUM_ARCH;
  localparam int FLW       = $clog2(NUM_FL);
  localparam int PTRW      = FLW + 1;
  localparam int NUM_ROB   = 32;
  localparam int ROBW      = $clog2(NUM_ROB);
  localparam int NUM_SUPER = 2;
  localparam int ARW       = 5;

  // Architectural zero register and its permanently mapped physical tag.
  localparam logic [ARW-1:0] ZERO_REG = 5'd31;
  localparam logic [PRW-1:0] ZERO_PR  = 6'd31;

  typedef logic [PRW-1:0]  pr_tag_t;
  // FIFO pointer: low FLW bits index the array, the top bit is the wrap flag.
  typedef logic [PTRW-1:0] fl_ptr_t;

  typedef struct packed {
    pr_tag_t [NUM_SUPER-1:0] T_idx;
  } FL_ROB_OUT_t;

  typedef struct packed {
    pr_tag_t [NUM_SUPER-1:0] Told_idx;
  } ROB_FL_OUT_t;

  typedef struct packed {
    pr_tag_t [NUM_SUPER-1:0] T_idx;
  } FL_MAP_TABLE_OUT_t;

endpackage

// File: rtl/free_list.sv
// Physical-register free list, 2-wide.
// A circular FIFO of free physical tags. Dispatch pops up to two tags from
// the head (only for slots whose destination is not the zero register),
// retire pushes up to two returned tags at the tail, and a branch rollback
// restores the head from a checkpoint stored per ROB entry, which hands the
// wrong-path tags back without touching the tail.
//
// Ports:
//   clock            rising-edge clock
//   reset            asynchronous, active-low
//   en               global stall, 0 holds all state
//   dispatch_en      both dispatch slots accepted this cycle
//   dest_idx         architectural destination per dispatch slot
//   ROB_idx          ROB entry receiving each dispatch slot
//   retire_en        retire valid per slot (slot 1 only with slot 0)
//   Told_idx         tag released by each retiring slot
//   rollback_en      mispredict squash
//   ROB_rollback_idx ROB entry just after the mispredicted branch
//   FL_valid         at least two free tags (registered)
//   T_idx            tags offered to dispatch slot 0/1 (combinational)
//   free_count       current number of free tags (registered)
module free_list
  import free_list_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      dispatch_en,
  input  logic [1:0][ARW-1:0]       dest_idx,
  input  logic [1:0][ROBW-1:0]      ROB_idx,
  input  logic [1:0]                retire_en,
  input  logic [1:0][PRW-1:0]       Told_idx,
  input  logic                      rollback_en,
  input  logic [ROBW-1:0]           ROB_rollback_idx,
  output logic                      FL_valid,
  output logic [1:0][PRW-1:0]       T_idx,
  output logic [PTRW-1:0]           free_count
);

  pr_tag_t fl_r   [NUM_FL];
  fl_ptr_t ckpt_r [NUM_ROB];
  fl_ptr_t head_r;
  fl_ptr_t tail_r;
  logic    fl_valid_r;
  fl_ptr_t free_count_r;

  logic      a0_s;
  logic      a1_s;
  fl_ptr_t   head_a0_s;
  fl_ptr_t   alloc_ptr_s;
  logic      push0_s;
  logic      push1_s;
  fl_ptr_t   tail_p0_s;
  fl_ptr_t   tail_next_s;
  logic      disp_s;
  logic      rb_s;
  logic [ROBW-1:0] rb_ckpt_idx_s;
  fl_ptr_t   head_next_s;
  fl_ptr_t   count_next_s;
  logic [1:0][PRW-1:0] t_idx_s;

  // Allocation needs, offered tags, push slots and next pointer values.
  always_comb begin
    a0_s          = (dest_idx[0] != ZERO_REG);
    a1_s          = (dest_idx[1] != ZERO_REG);
    head_a0_s     = head_r + fl_ptr_t'(a0_s);
    alloc_ptr_s   = head_a0_s + fl_ptr_t'(a1_s);
    t_idx_s[0]    = ZERO_PR;
    t_idx_s[1]    = ZERO_PR;
    if (a0_s) begin
      t_idx_s[0] = fl_r[head_r[FLW-1:0]];
    end else begin
      t_idx_s[0] = ZERO_PR;
    end
    // Slot 1 takes the entry after slot 0 only if slot 0 consumed one.
    if (a1_s) begin
      t_idx_s[1] = fl_r[head_a0_s[FLW-1:0]];
    end else begin
      t_idx_s[1] = ZERO_PR;
    end
    // The zero tag is never recycled, even if the ROB hands it back.
    push0_s       = en & retire_en[0] & (Told_idx[0] != ZERO_PR);
    push1_s       = en & retire_en[1] & (Told_idx[1] != ZERO_PR);
    tail_p0_s     = tail_r + fl_ptr_t'(push0_s);
    tail_next_s   = tail_p0_s + fl_ptr_t'(push1_s);
    disp_s        = en & dispatch_en & ~rollback_en;
    rb_s          = en & rollback_en;
    // The checkpoint lives in the branch's own entry, one before the index.
    rb_ckpt_idx_s = ROB_rollback_idx - ROBW'(1'b1);
    if (rb_s) begin
      head_next_s = ckpt_r[rb_ckpt_idx_s];
    end else if (disp_s) begin
      head_next_s = alloc_ptr_s;
    end else begin
      head_next_s = head_r;
    end
    count_next_s  = tail_next_s - head_next_s;
  end

  // FIFO storage, pointers, checkpoints and registered status.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FL; i++) begin
        fl_r[i] <= pr_tag_t'(NUM_ARCH + i);
      end
      for (int j = 0; j < NUM_ROB; j++) begin
        ckpt_r[j] <= {PTRW{1'b0}};
      end
      head_r       <= {PTRW{1'b0}};
      tail_r       <= fl_ptr_t'(NUM_FL);
      fl_valid_r   <= 1'b1;
      free_count_r <= fl_ptr_t'(NUM_FL);
    end else if (en) begin
      head_r <= head_next_s;
      tail_r <= tail_next_s;
      if (push0_s) begin
        fl_r[tail_r[FLW-1:0]] <= Told_idx[0];
      end
      if (push1_s) begin
        fl_r[tail_p0_s[FLW-1:0]] <= Told_idx[1];
      end
      // Each entry remembers the head just past its own allocation.
      if (disp_s) begin
        ckpt_r[ROB_idx[0]] <= head_a0_s;
        ckpt_r[ROB_idx[1]] <= alloc_ptr_s;
      end
      fl_valid_r   <= (count_next_s >= fl_ptr_t'(2));
      free_count_r <= count_next_s;
    end
  end

  assign FL_valid   = fl_valid_r;
  assign free_count = free_count_r;
  assign T_idx      = t_idx_s;

endmodule

// File: tb/tb_free_list.sv
// Randomised and directed bench for free_list with a queue-based scoreboard.
// The reference model keeps every tag ever placed on the free list in an
// unbounded log indexed by absolute position; the head is an absolute
// position into that log and checkpoints store absolute positions.
module tb_free_list;

  logic            clock;
  logic            reset;
  logic            en;
  logic            dispatch_en;
  logic [1:0][4:0] dest_idx;
  logic [1:0][4:0] ROB_idx;
  logic [1:0]      retire_en;
  logic [1:0][5:0] Told_idx;
  logic            rollback_en;
  logic [4:0]      ROB_rollback_idx;
  logic            FL_valid;
  logic [1:0][5:0] T_idx;
  logic [5:0]      free_count;

  free_list dut (
    .clock(clock), .reset(reset), .en(en), .dispatch_en(dispatch_en),
    .dest_idx(dest_idx), .ROB_idx(ROB_idx), .retire_en(retire_en),
    .Told_idx(Told_idx), .rollback_en(rollback_en),
    .ROB_rollback_idx(ROB_rollback_idx), .FL_valid(FL_valid),
    .T_idx(T_idx), .free_count(free_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cnt;
    bit vld;
    int t0;
    int t1;
    bit t0ok;
    bit t1ok;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    passed;
  int    total;

  // Reference model state.
  int log_q[$];
  int hd;
  int ck[32];
  int pool[$];

  function automatic void chk(string n, int act, int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s actual=%0d required=%0d", n, act, req);
  endfunction

  function automatic void model_reset();
    log_q.delete();
    for (int i = 0; i < 32; i++) log_q.push_back(32 + i);
    hd = 0;
    for (int i = 0; i < 32; i++) ck[i] = 0;
    pool.delete();
  endfunction

  function automatic int mcount();
    return log_q.size() - hd;
  endfunction

  // Monitor: compares DUT outputs against the oldest pending expectation.
  always @(negedge clock) begin
    exp_t  e;
    string n;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      chk({n, ".free_count"}, int'(free_count), e.cnt);
      chk({n, ".FL_valid"}, int'(FL_valid), int'(e.vld));
      if (e.t0ok) chk({n, ".T_idx0"}, int'(T_idx[0]), e.t0);
      if (e.t1ok) chk({n, ".T_idx1"}, int'(T_idx[1]), e.t1);
      chk({n, ".count_le_32"}, int'(free_count <= 6'd32), 1);
    end
  end

  task automatic idle_inputs();
    en = 1'b1; dispatch_en = 1'b0; rollback_en = 1'b0; retire_en = 2'b00;
    dest_idx[0] = 5'd31; dest_idx[1] = 5'd31;
    ROB_idx[0] = 5'd0; ROB_idx[1] = 5'd0;
    Told_idx[0] = 6'd31; Told_idx[1] = 6'd31;
    ROB_rollback_idx = 5'd0;
  endtask

  // One cycle of stimulus; queues the expectation and advances the model.
  task automatic step(input bit e, input bit de, input int d0, input int d1,
                      input int rob0, input int rob1, input bit [1:0] re,
                      input int k0, input int k1, input bit rb, input int rbi,
                      input string nm);
    exp_t x;
    int   a0, a1, c;
    @(negedge clock);
    en = e; dispatch_en = de; rollback_en = rb; retire_en = re;
    dest_idx[0] = 5'(d0); dest_idx[1] = 5'(d1);
    ROB_idx[0] = 5'(rob0); ROB_idx[1] = 5'(rob1);
    Told_idx[0] = 6'(k0); Told_idx[1] = 6'(k1);
    ROB_rollback_idx = 5'(rbi);
    a0 = (d0 != 31) ? 1 : 0;
    a1 = (d1 != 31) ? 1 : 0;
    c = mcount();
    x.cnt = c;
    x.vld = (c >= 2);
    x.t0ok = (a0 == 0) || (hd < log_q.size());
    x.t1ok = (a1 == 0) || (hd + a0 < log_q.size());
    x.t0 = 31;
    x.t1 = 31;
    if (a0 == 1 && x.t0ok) x.t0 = log_q[hd];
    if (a1 == 1 && x.t1ok) x.t1 = log_q[hd + a0];
    exp_q.push_back(x);
    nm_q.push_back(nm);
    if (e) begin
      if (rb) begin
        hd = ck[(rbi + 31) % 32];
      end else if (de) begin
        ck[rob0] = hd + a0;
        ck[rob1] = hd + a0 + a1;
        hd = hd + a0 + a1;
      end
      if (re[0] && k0 != 31) log_q.push_back(k0);
      if (re[1] && k1 != 31) log_q.push_back(k1);
    end
  endtask

  // Asynchronous reset asserted mid-cycle while a dispatch/retire is in flight.
  task automatic do_reset();
    @(negedge clock);
    dispatch_en = 1'b1; dest_idx[0] = 5'd3; dest_idx[1] = 5'd4;
    retire_en = 2'b01; Told_idx[0] = 6'd9;
    #3;
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    #1;
    idle_inputs();
    reset = 1'b1;
  endtask

  initial begin
    int rob;
    clock = 1'b0;
    reset = 1'b0;
    passed = 0;
    total = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Reset state and first allocations.
    step(1, 0, 31, 31, 0, 0, 2'b00, 31, 31, 0, 0, "reset_state");
    step(1, 1, 1, 2, 0, 1, 2'b00, 31, 31, 0, 0, "disp_1_2");
    step(1, 0, 1, 2, 0, 0, 2'b00, 31, 31, 0, 0, "after_disp");
    step(1, 1, 31, 5, 2, 3, 2'b00, 31, 31, 0, 0, "disp_zero_slot0");
    step(1, 1, 31, 5, 4, 5, 2'b00, 31, 31, 0, 0, "disp_zero_again");
    rob = 6;
    while (mcount() > 2) begin
      step(1, 1, 3, 4, rob % 32, (rob + 1) % 32, 2'b00, 31, 31, 0, 0, "drain_pair");
      rob += 2;
    end
    step(1, 1, 3, 4, 20, 21, 2'b11, 40, 31, 0, 0, "last_pair_retire");
    step(1, 0, 3, 4, 0, 0, 2'b00, 31, 31, 0, 0, "count_one");
    step(1, 0, 31, 31, 0, 0, 2'b01, 41, 31, 0, 0, "zero_dests");
    step(0, 0, 3, 31, 0, 0, 2'b11, 42, 43, 0, 0, "stall_hold");
    step(1, 0, 3, 4, 0, 0, 2'b00, 31, 31, 0, 0, "after_stall");

    // Rollback: branch in ROB 5 dispatched at head 4, successors squashed.
    do_reset();
    step(1, 1, 1, 2, 0, 1, 2'b00, 31, 31, 0, 0, "rb_pre0");
    step(1, 1, 3, 4, 2, 3, 2'b00, 31, 31, 0, 0, "rb_pre1");
    step(1, 1, 31, 7, 5, 6, 2'b00, 31, 31, 0, 0, "rb_branch");
    step(1, 1, 8, 9, 7, 8, 2'b00, 31, 31, 0, 0, "rb_wrong0");
    step(1, 1, 10, 11, 9, 10, 2'b00, 31, 31, 0, 0, "rb_wrong1");
    step(1, 1, 12, 13, 11, 12, 2'b11, 50, 51, 1, 6, "rb_squash");
    step(1, 0, 12, 13, 0, 0, 2'b00, 31, 31, 0, 0, "rb_after");

    // Randomised steady-state traffic across many pointer wraps.
    do_reset();
    rob = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      bit       e, de;
      int       d0, d1, k0, k1, nret, a0;
      bit [1:0] re;
      e  = ($urandom_range(0, 9) != 0);
      de = (mcount() >= 2) && ($urandom_range(0, 3) != 0);
      d0 = ($urandom_range(0, 4) == 0) ? 31 : $urandom_range(0, 30);
      d1 = ($urandom_range(0, 4) == 0) ? 31 : $urandom_range(0, 30);
      nret = $urandom_range(0, 2);
      if (nret > pool.size()) nret = pool.size();
      re = 2'b00; k0 = 31; k1 = 31;
      if (nret >= 1) begin re[0] = 1'b1; k0 = pool[0]; end
      if (nret == 2) begin re[1] = 1'b1; k1 = pool[1]; end
      if (nret == 0 && $urandom_range(0, 3) == 0) re = 2'b01;
      if (e) begin
        a0 = (d0 != 31) ? 1 : 0;
        for (int r = 0; r < nret; r++) void'(pool.pop_front());
        if (de) begin
          if (d0 != 31) pool.push_back(log_q[hd]);
          if (d1 != 31) pool.push_back(log_q[hd + a0]);
        end
      end
      step(e, de, d0, d1, rob % 32, (rob + 1) % 32, re, k0, k1, 0, 0, "rand");
      if (e && de) rob += 2;
    end
    step(1, 0, 1, 2, 0, 0, 2'b00, 31, 31, 0, 0, "rand_end");
    chk("pool_plus_free", mcount() + pool.size(), 32);

    repeat (4) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
